// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, double-buffered duty per channel.
// Define PWM_RAMP_EN to slew-limit duty changes by RAMP_STEP per period (soft start/stop).
module pwm_multi #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int PERIOD    = 50000,
  parameter int RAMP_STEP = 500
) (
  input  logic                      CLOCK50,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] speed,
  input  logic                      load,
  input  logic                      enable,
  output logic [CHANNELS-1:0]       PWM_out,
  output logic                      busy,
  output logic                      period_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW = $clog2(PERIOD + 1);
  localparam int SW = (WIDTH > AW) ? WIDTH : AW;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [AW-1:0] DUTY_FULL = AW'(PERIOD);

  if ((WIDTH < 31) && ((1 << WIDTH) <= PERIOD)) begin : g_width_check
    $error("pwm_multi: WIDTH cannot represent PERIOD");
  end
  if (RAMP_STEP < 1) begin : g_step_check
    $error("pwm_multi: RAMP_STEP must be at least 1");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       tgt_q [CHANNELS];
  logic [AW-1:0]       tgt_d [CHANNELS];
  logic [AW-1:0]       act_q [CHANNELS];
  logic [AW-1:0]       act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                busy_q, busy_d;
  logic                tick_q, tick_d;
  logic                wrap;

  // Requests at or above PERIOD saturate to 100 % duty.
  function automatic logic [AW-1:0] clamp_req(input logic [WIDTH-1:0] req);
    logic [SW-1:0] wide;
    wide = SW'(req);
    if (wide >= SW'(PERIOD)) return DUTY_FULL;
    return AW'(wide);
  endfunction

`ifdef PWM_RAMP_EN
  localparam int RW = AW + 1;

  // Move act toward tgt by at most RAMP_STEP; the extra bit keeps the sums exact.
  function automatic logic [AW-1:0] ramp_duty(input logic [AW-1:0] act,
                                              input logic [AW-1:0] tgt);
    logic [RW-1:0] act_w, tgt_w, step_w;
    act_w  = {1'b0, act};
    tgt_w  = {1'b0, tgt};
    step_w = RW'(RAMP_STEP);
    if (act_w + step_w < tgt_w) return AW'(act_w + step_w);
    if (act_w > tgt_w + step_w) return AW'(act_w - step_w);
    return tgt;
  endfunction
`endif

  // NOTE: every signal written here gets its default first, so no latch can be inferred.
  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tick_d = wrap;
    busy_d = 1'b0;
    pwm_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_d[i] = tgt_q[i];
      act_d[i] = act_q[i];
      if (load) tgt_d[i] = clamp_req(speed[i*WIDTH +: WIDTH]);
      // Disable wins over a same-cycle wrap; the wrap always sees the pre-load target.
      if (!enable) begin
        act_d[i] = '0;
      end else if (wrap) begin
`ifdef PWM_RAMP_EN
        act_d[i] = ramp_duty(act_q[i], tgt_q[i]);
`else
        act_d[i] = tgt_q[i];
`endif
      end
      pwm_d[i] = enable && (AW'(cnt_q) < act_q[i]);
      busy_d   = busy_d | (act_q[i] != tgt_q[i]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pwm_q  <= '0;
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      // NOTE: the duty arrays are a few flops per channel, not a RAM, so they take the async reset.
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= '0;
        act_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      busy_q <= busy_d;
      tick_q <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        tgt_q[i] <= tgt_d[i];
        act_q[i] <= act_d[i];
      end
    end
  end

  assign PWM_out     = pwm_q;
  assign busy        = busy_q;
  assign period_tick = tick_q;

endmodule
